// File: rtl/mod_down_counter.sv
// mod_down_counter: modulo-MOD down-counter with borrow pulse and a
// 50%-duty divided output that toggles on every wrap from 0 back to MOD-1.
// A synchronous load presets the count and takes priority over enable.
// Out-of-range preset values saturate to MOD-1.
//
// Optional feature macro: MOD_DOWN_ONESHOT_EN
//   When defined, adds input 'oneshot'. With oneshot=1 the counter parks
//   at 0 instead of wrapping. Only load or rst restarts it.
module mod_down_counter #(
  parameter int MOD   = 6,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             rst,
`ifdef MOD_DOWN_ONESHOT_EN
  input  logic             oneshot,
`endif
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             mainOut
);

  // Wrap target. The modulus is widened by one bit so that MOD == 2^WIDTH
  // still compares correctly against a WIDTH-bit preset value.
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             main_q, main_d;
  logic             wrap_allowed;

  // Decide whether reaching zero may wrap (oneshot parks the count at zero).
  always_comb begin
`ifdef MOD_DOWN_ONESHOT_EN
    wrap_allowed = ~oneshot;
`else
    wrap_allowed = 1'b1;
`endif
  end

  // Next-state logic: load > enable > hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    count_d  = count_q;
    borrow_d = 1'b0;
    main_d   = main_q;
    if (load) begin
      count_d = ({1'b0, loadVal} >= MOD_EXT) ? TOP : loadVal;
    end else if (enable) begin
      if (count_q == '0) begin
        if (wrap_allowed) begin
          count_d  = TOP;
          borrow_d = 1'b1;
          main_d   = ~main_q;
        end
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values of the others, regardless of statement order.
    if (rst) begin
      count_q  <= TOP;
      borrow_q <= 1'b0;
      main_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
      main_q   <= main_d;
    end
  end

  assign out     = count_q;
  assign borrow  = borrow_q;
  assign mainOut = main_q;

endmodule

// File: tb/tb_mod_down_counter.sv
// Directed self-checking bench for mod_down_counter (MOD=6, WIDTH=3).
// Expected values are hand-computed constants; the oneshot section is
// compiled only when MOD_DOWN_ONESHOT_EN is defined.
module tb_mod_down_counter;

  logic       clock;
  logic       rst;
  logic       enable;
  logic       load;
  logic [2:0] loadVal;
  logic [2:0] out;
  logic       borrow;
  logic       mainOut;
`ifdef MOD_DOWN_ONESHOT_EN
  logic       oneshot;
`endif

  int errors = 0;
  int checks = 0;

  mod_down_counter #(.MOD(6), .WIDTH(3)) dut (
    .clock   (clock),
    .rst     (rst),
`ifdef MOD_DOWN_ONESHOT_EN
    .oneshot (oneshot),
`endif
    .enable  (enable),
    .load    (load),
    .loadVal (loadVal),
    .out     (out),
    .borrow  (borrow),
    .mainOut (mainOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_out,
                           input logic e_borrow, input logic e_main);
    check({tag, ".out"},     32'(out),     32'(e_out));
    check({tag, ".borrow"},  32'(borrow),  32'(e_borrow));
    check({tag, ".mainOut"}, 32'(mainOut), 32'(e_main));
  endtask

  logic [2:0] seq_out  [12] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5,
                                3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
  logic       seq_brw  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  logic       seq_main [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    load    = 1'b0;
    loadVal = '0;
`ifdef MOD_DOWN_ONESHOT_EN
    oneshot = 1'b0;
`endif

    // 1. Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_all("reset_async", 3'd5, 1'b0, 1'b0);
    @(negedge clock);
    rst = 1'b0;

    // 2. Twelve enabled edges from reset.
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_all($sformatf("count_e%0d", i + 1), seq_out[i], seq_brw[i], seq_main[i]);
    end

    // Six more edges to get mainOut high, so 'unchanged by load' is visible.
    for (int i = 0; i < 6; i++) step();
    check_all("second_wrap", 3'd5, 1'b1, 1'b1);

    // 3. Load beats enable; out-of-range presets saturate.
    load = 1'b1; loadVal = 3'd2;
    step();
    check_all("load_2", 3'd2, 1'b0, 1'b1);
    loadVal = 3'd7;
    step();
    check_all("load_7_sat", 3'd5, 1'b0, 1'b1);
    loadVal = 3'd6;
    step();
    check_all("load_6_sat", 3'd5, 1'b0, 1'b1);
    loadVal = 3'd0;
    step();
    check_all("load_0", 3'd0, 1'b0, 1'b1);

    // Hold at zero with enable low: no wrap, no borrow.
    load = 1'b0; enable = 1'b0;
    step();
    check_all("hold_at_0", 3'd0, 1'b0, 1'b1);

    // 4. Hold at 3 for four edges, then re-enable.
    load = 1'b1; loadVal = 3'd3;
    step();
    check("load_3.out", 32'(out), 32'd3);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold%0d.out", i), 32'(out), 32'd3);
      check($sformatf("hold%0d.borrow", i), 32'(borrow), 32'd0);
    end
    enable = 1'b1;
    step();
    check_all("reenable", 3'd2, 1'b0, 1'b1);

    // 5. Asynchronous reset pulse between edges while out=1.
    step();
    check_all("pre_rst", 3'd1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all("rst_mid", 3'd5, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_all("post_rst", 3'd4, 1'b0, 1'b0);

`ifdef MOD_DOWN_ONESHOT_EN
    // 6. Oneshot parks at zero until the next load.
    oneshot = 1'b1;
    load = 1'b1; loadVal = 3'd1; enable = 1'b0;
    step();
    check("os_load1.out", 32'(out), 32'd1);
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("os_e%0d", i + 1), 3'd0, 1'b0, 1'b0);
    end
    load = 1'b1; loadVal = 3'd4;
    step();
    check_all("os_reload", 3'd4, 1'b0, 1'b0);
    load = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
